// File: rtl/tx_engine_pkg.sv
// Shared constants, FSM encoding and frame-building helper for the UART transmit engine.
package tx_engine_pkg;

  localparam int unsigned RATE_W     = 19;
  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned CNT_W      = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int unsigned SLOT_START = 0;
  localparam int unsigned SLOT_D0    = 1;
  localparam int unsigned SLOT_D7    = 8;
  localparam int unsigned SLOT_PAR   = 9;
  localparam int unsigned SLOT_STOP  = 10;

  // Slot 8 carries data[7] or parity; slot 9 carries parity only for 8-bit frames.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data,
                                                        input logic eight,
                                                        input logic pen,
                                                        input logic ohel);
    logic                  par;
    logic [FRAME_BITS-1:0] f;
    par               = ohel ^ (^data[6:0]) ^ (eight & data[7]);
    f                 = '1;
    f[SLOT_START]     = 1'b0;
    f[SLOT_D0 +: 7]   = data[6:0];
    if (eight)    f[SLOT_D7] = data[7];
    else if (pen) f[SLOT_D7] = par;
    if (eight && pen) f[SLOT_PAR] = par;
    f[SLOT_STOP]      = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/tx_engine_bit_timer.sv
// Bit-period timer: single-cycle btu on terminal count, cleared while disabled.
module tx_bit_timer
  import tx_engine_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [RATE_W-1:0] i_rate,
  output logic              o_btu
);

  logic [RATE_W-1:0] cnt_q;
  logic [RATE_W-1:0] cnt_d;
  logic [RATE_W-1:0] last;

  // A rate of zero behaves like one; >= keeps a live rate decrease from overrunning.
  always_comb begin
    last  = (i_rate == '0) ? '0 : i_rate - RATE_W'(1);
    o_btu = i_en && (cnt_q >= last);
    cnt_d = cnt_q + RATE_W'(1);
    if (!i_en || o_btu) cnt_d = '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_engine.sv
// UART transmit engine: latches a byte on load and shifts an 11-slot LSB-first frame onto o_tx.
module tx_engine
  import tx_engine_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_eight,
  input  logic              i_pen,
  input  logic              i_ohel,
  input  logic              i_load,
  input  logic [7:0]        i_data,
  output logic              o_tx,
  output logic              o_txrdy,
  output logic              o_done
);

  logic [1:0]            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]            data_q, data_d;
  logic                  eight_q, eight_d;
  logic                  pen_q, pen_d;
  logic                  ohel_q, ohel_d;
  logic                  tx_q, tx_d;
  logic                  txrdy_q, txrdy_d;
  logic                  done_q, done_d;
  logic                  btu;

  tx_bit_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (state_q == ST_SHIFT),
    .i_rate (i_rate),
    .o_btu  (btu)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    eight_d   = eight_q;
    pen_d     = pen_q;
    ohel_d    = ohel_q;
    tx_d      = tx_q;
    txrdy_d   = txrdy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        txrdy_d = 1'b1;
        if (i_load && txrdy_q) begin
          data_d  = i_data;
          eight_d = i_eight;
          pen_d   = i_pen;
          ohel_d  = i_ohel;
          txrdy_d = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shift_d   = build_frame(data_q, eight_q, pen_q, ohel_q);
        tx_d      = shift_d[SLOT_START];
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (btu) begin
          shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
          tx_d      = shift_d[0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
            bit_cnt_d = '0;
            done_d    = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      data_q    <= '0;
      eight_q   <= 1'b0;
      pen_q     <= 1'b0;
      ohel_q    <= 1'b0;
      tx_q      <= 1'b1;
      txrdy_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      eight_q   <= eight_d;
      pen_q     <= pen_d;
      ohel_q    <= ohel_d;
      tx_q      <= tx_d;
      txrdy_q   <= txrdy_d;
      done_q    <= done_d;
    end
  end

  assign o_tx    = tx_q;
  assign o_txrdy = txrdy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_tx_engine.sv
// Scoreboard bench for tx_engine: expected line bits queued at load, checked per bit slot.
module tb_tx_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [18:0] rate;
  logic        eight, pen, ohel, load;
  logic [7:0]  data;
  logic        tx, txrdy, done;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_q[$];

  tx_engine dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_rate  (rate),
    .i_eight (eight),
    .i_pen   (pen),
    .i_ohel  (ohel),
    .i_load  (load),
    .i_data  (data),
    .o_tx    (tx),
    .o_txrdy (txrdy),
    .o_done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected frame derived from the slot table: start, data LSB first, slot 8/9, stop fill.
  task automatic push_frame(input logic [7:0] d, input logic e, input logic p, input logic o);
    logic par;
    par = e ? ~^{~o, d} : ~^{~o, d[6:0]};
    exp_q.push_back(1'b0);
    for (int i = 0; i < 7; i++) exp_q.push_back(d[i]);
    if (e)      exp_q.push_back(d[7]);
    else if (p) exp_q.push_back(par);
    else        exp_q.push_back(1'b1);
    exp_q.push_back((e && p) ? par : 1'b1);
    exp_q.push_back(1'b1);
  endtask

  // Called at a negedge; drives a one-cycle load and queues the frame if it will be accepted.
  task automatic drive_load(input logic [7:0] d, input logic e, input logic p, input logic o);
    data = d; eight = e; pen = p; ohel = o; load = 1'b1;
    if (txrdy === 1'b1) push_frame(d, e, p, o);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic check_frame(input int r);
    int   waited;
    logic e;
    waited = 0;
    while (tx !== 1'b0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      check("start_timeout", 32'(tx), 32'd0);
      exp_q.delete();
      return;
    end
    check("start_lat", 32'(waited), 32'd1);
    check("busy_rdy", 32'(txrdy), 32'd0);
    for (int s = 0; s < 11; s++) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 32'(exp_q.size()), 32'd1);
        return;
      end
      e = exp_q.pop_front();
      check($sformatf("slot%0d_first", s), 32'(tx), 32'(e));
      repeat (r - 1) @(negedge clk);
      check($sformatf("slot%0d_last", s), 32'(tx), 32'(e));
      if (s < 10) check($sformatf("slot%0d_nodone", s), 32'(done), 32'd0);
      @(negedge clk);
    end
    check("done_pulse", 32'(done), 32'd1);
    check("done_rdy_low", 32'(txrdy), 32'd0);
    check("done_tx_idle", 32'(tx), 32'd1);
    @(negedge clk);
    check("done_clear", 32'(done), 32'd0);
    check("rdy_rise", 32'(txrdy), 32'd1);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    int bad_tx, bad_rdy, n_done;
    bad_tx = 0; bad_rdy = 0; n_done = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1)    bad_tx++;
      if (txrdy !== 1'b1) bad_rdy++;
      if (done !== 1'b0)  n_done++;
    end
    check({tag, "_tx"}, 32'(bad_tx), 32'd0);
    check({tag, "_rdy"}, 32'(bad_rdy), 32'd0);
    check({tag, "_done"}, 32'(n_done), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rate = 19'd109; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    load = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_rdy", 32'(txrdy), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    idle_check("idle200", 200);

    drive_load(8'hA5, 1'b1, 1'b0, 1'b0);
    check_frame(109);
    drive_load(8'h41, 1'b0, 1'b1, 1'b0);
    check_frame(109);
    drive_load(8'h41, 1'b0, 1'b1, 1'b1);
    check_frame(109);

    // Frame format inputs flip mid-frame; the frame in flight must not change.
    drive_load(8'hFF, 1'b1, 1'b1, 1'b1);
    fork
      check_frame(109);
      begin
        repeat (400) @(negedge clk);
        eight = 1'b0; pen = 1'b0; ohel = 1'b0; data = 8'h00;
      end
    join

    // Load while busy is dropped; then a back-to-back load on the first ready cycle.
    drive_load(8'h3C, 1'b1, 1'b0, 1'b0);
    fork
      check_frame(109);
      begin
        repeat (500) @(negedge clk);
        check("busy_ignore_rdy", 32'(txrdy), 32'd0);
        drive_load(8'h00, 1'b1, 1'b0, 1'b0);
      end
    join
    drive_load(8'h5A, 1'b1, 1'b1, 1'b0);
    check_frame(109);
    idle_check("no_queue", 50);

    // Asynchronous reset during slot 4 (a zero bit of 8'hC3).
    drive_load(8'hC3, 1'b1, 1'b1, 1'b0);
    repeat (487) @(negedge clk);
    check("pre_rst_tx", 32'(tx), 32'd0);
    rst = 1'b1;
    #1;
    check("arst_tx", 32'(tx), 32'd1);
    check("arst_rdy", 32'(txrdy), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    idle_check("post_rst", 20);
    drive_load(8'h96, 1'b1, 1'b1, 1'b1);
    check_frame(109);

    // Short and zero rates (zero behaves as one cycle per bit).
    rate = 19'd3;
    drive_load(8'h6B, 1'b0, 1'b0, 1'b0);
    check_frame(3);
    rate = 19'd0;
    drive_load(8'h0F, 1'b0, 1'b1, 1'b1);
    check_frame(1);
    idle_check("final_idle", 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tx_engine.md
Name: tx_engine

Overview:
- UART transmit engine; the transmit-side counterpart of the RX_CONTROL receive path in the same SOPC UART.
- Accepts a byte from the processor-side interface with a load strobe and serialises it onto the TX line.
- Frame is an 11-bit LSB-first frame: start, 7/8 data bits, optional parity, stop fill.
- Shares the baud-rate and frame-format configuration inputs (i_rate, i_eight, i_pen) with the receiver.

Parameters:
- RATE_W, 19, width of the bit-period count input.
- FRAME_BITS, 11, total bit slots shifted per frame (start + 10).

Ports:
- i_clk  input  1  system clock (100 MHz in system).
- i_rst  input  1  asynchronous, active-high reset.
- i_rate  input  RATE_W  bit period in i_clk cycles (109 for 921600 baud).
- i_eight  input  1  1 = 8 data bits, 0 = 7 data bits.
- i_pen  input  1  1 = parity bit enabled.
- i_ohel  input  1  parity sense: 1 = odd, 0 = even.
- i_load  input  1  one-cycle write strobe; i_data is valid with it.
- i_data  input  8  byte to send; bit 7 is ignored when i_eight=0.
- o_tx  output  1  serial line; idles high.
- o_txrdy  output  1  high = engine idle, next i_load is accepted.
- o_done  output  1  one-cycle pulse when the last bit slot of a frame completes.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - o_tx=1, o_txrdy=1, o_done=0.
  - Shift register is all ones; counters are 0; FSM is in IDLE.
- FSM states:
  - IDLE -> LOAD on i_load && o_txrdy.
  - LOAD -> SHIFT after 1 cycle.
  - SHIFT -> IDLE after the FRAME_BITS-th btu.
- Load acceptance:
  - When i_load is sampled high in IDLE at edge N: latch i_data, i_eight, i_pen and i_ohel; o_txrdy=0 from edge N.
  - i_load while o_txrdy=0 is ignored; no queueing.
  - Configuration changes mid-frame have no effect on the frame in flight.
- LOAD state (edge N+1): load the 11-bit shift register and drive o_tx=0 (start bit). The bit timer starts from 0.
- Frame bit slots 1..10, after the start bit:
  - Slots 1..7: data[6:0].
  - Slot 8: data[7] if eight; else parity if pen; else 1.
  - Slot 9: parity if eight && pen; else 1.
  - Slot 10: 1.
- Parity:
  - Even: XOR of the transmitted data bits (7 or 8).
  - Odd: inverted XOR of the transmitted data bits.
- Bit timer:
  - Counts 0..i_rate-1 while in SHIFT; btu is a 1-cycle pulse on the terminal count, then the count wraps to 0.
  - Bit period is exactly i_rate cycles; i_rate=0 is treated as 1.
  - i_rate is sampled live; it is not latched.
- On each btu:
  - Shift right, shifting in 1; o_tx = shift[0] (registered, glitch-free).
  - Increment the bit counter.
- On the btu that brings the bit counter to FRAME_BITS:
  - o_done=1 for that cycle; FSM -> IDLE.
  - o_txrdy=1 at the next edge; o_tx stays 1.
- Timing:
  - o_tx falls at N+1.
  - The frame occupies 11*i_rate cycles from N+1.
  - A back-to-back load is accepted on the first cycle o_txrdy=1; the gap between stop fill and the next start bit is 2 cycles.
- Simultaneous reset with i_load: reset wins; the load is discarded.

Decomposition:
- Shared package holds:
  - RATE_W and FRAME_BITS.
  - The FSM state encoding (IDLE, LOAD, SHIFT).
  - The frame slot index constants.
- One natural sub-module: tx_bit_timer.
  - Inputs: i_clk, i_rst, i_en, i_rate.
  - Output: o_btu.
  - Counter clears when i_en is low.

Test Plan:
- Reset, then idle 200 cycles -> o_tx=1, o_txrdy=1, o_done never asserts.
- rate=109, eight=1, pen=0, load 8'hA5 -> o_tx sequence 0,1,0,1,0,0,1,0,1,1,1, each bit 109 cycles; o_done after 1199 cycles; o_txrdy rises the next cycle.
- rate=109, eight=0, pen=1, ohel=0, load 8'h41 -> data bits 1000001, parity slot=0 (even), then 1,1; repeat with ohel=1 -> parity=1.
- eight=1, pen=1, ohel=1, load 8'hFF -> slot 9 parity=1; change eight/pen mid-frame -> frame unchanged.
- Second i_load while o_txrdy=0 -> ignored, first frame intact; load on the first o_txrdy=1 cycle -> start bit 2 cycles after previous stop fill.
- Assert i_rst at slot 4 -> o_tx=1 and o_txrdy=1 asynchronously; the next load sends a clean full frame.
